ps2_keyboard_receiver: RTL
==========================

# ps2_keyboard_receiver

Receives PS/2 keyboard frames on `ps2c`/`ps2d` and delivers validated 8-bit scan codes to the input register and FGI path of the basic computer. It sits directly upstream of the input register. It produces `keyboard_input_data` and a one-cycle `input_arrived_flag` pulse that sets FGI. It synchronises and deglitches the slow external PS/2 clock, decodes the start/data/parity/stop frame, aborts stalled frames, and optionally suppresses key-release (break) codes.

## Interface
- `FILTER_LEN`, 8: consecutive identical samples needed before the filtered PS/2 clock changes level (2..15).
- `TIMEOUT_CYCLES`, 50000: idle `clk` cycles allowed between PS/2 falling edges inside a frame before the frame is aborted.
- `SUPPRESS_BREAK`, 1: when 1, the `F0` prefix and the code that follows it are not delivered.
- `clk` in 1: system clock. All state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `ps2c` in 1: raw PS/2 clock from the connector. Asynchronous, idles high.
- `ps2d` in 1: raw PS/2 data from the connector. Asynchronous, idles high.
- `rx_en` in 1: when 0, frames in progress finish but any new start bit is ignored.
- `keyboard_input_data` out 8: last delivered scan code. Holds its value between deliveries.
- `input_arrived_flag` out 1: one-cycle pulse when a new code is placed on `keyboard_input_data`.
- `parity_error` out 1: one-cycle pulse when a frame is discarded for bad parity.
- `frame_error` out 1: one-cycle pulse when a frame is discarded for a bad stop bit or a timeout.
- `busy` out 1: high while the state is not IDLE.

## Operation
- **Synchronisers.** `ps2c` and `ps2d` each pass through a 2-FF synchroniser. Both synchroniser stages reset to 1.
- **Clock filter.** A filter counter tracks the synchronised `ps2c`.
  - The filtered clock `fc` goes to 1 after `FILTER_LEN` consecutive 1 samples, and to 0 after `FILTER_LEN` consecutive 0 samples.
  - Any differing sample restarts the count.
  - `fc` resets to 1.
- **Falling edge.** A falling edge (`fe`) is a registered `fc` of 1 followed by a current `fc` of 0. On an `fe` cycle the synchronised `ps2d` is sampled.
- **State machine.**
  - IDLE: on `fe` with data=0 and `rx_en`=1, go to DATA with bit count 0. On data=1 or `rx_en`=0, stay in IDLE with no error.
  - DATA: on each `fe`, shift data in LSB-first. After the 8th bit, go to PARITY.
  - PARITY: on `fe`, store the parity bit and go to STOP.
  - STOP: on `fe`, evaluate the frame as below, then go to IDLE.
- **Frame evaluation in STOP.**
  - The frame is valid when the stop bit is 1 and odd parity holds, i.e. XOR of the 8 data bits and the parity bit equals 1.
  - Stop bit 0: pulse `frame_error` and discard the frame. This check takes priority over parity.
  - Stop bit 1 with bad parity: pulse `parity_error` and discard the frame.
- **Timeout.**
  - In DATA, PARITY and STOP, a counter increments every cycle and clears on `fe`.
  - When the counter reaches `TIMEOUT_CYCLES`, go to IDLE, pulse `frame_error`, and discard the partial frame.
  - In IDLE the counter is held at 0.
- **Break suppression** (`SUPPRESS_BREAK`=1).
  - A valid `F0` sets `break_pending` and is not delivered.
  - The next valid code clears `break_pending` and is not delivered.
  - A parity or frame error also clears `break_pending`.
  - `E0` and every other code are delivered normally.
  - With `SUPPRESS_BREAK`=0, every valid code is delivered, including `F0`.
- **Delivery.** `keyboard_input_data` is loaded and `input_arrived_flag` pulses together. There is no back-pressure: a new code overwrites the held one, and FGI handling is the consumer's concern.
- **Reset values.** `keyboard_input_data`=0x00, and all flags and pulses 0. State IDLE, `break_pending`=0, counters 0. `reset` wins over every other event, including mid-frame; the partial frame is dropped with no error pulse.

## Timing
- Latency from the synchronised `ps2c` low level to `fc`=0 is `FILTER_LEN` cycles. Add the 2 synchroniser cycles for the raw pin.
- For a valid stop bit, `input_arrived_flag` is high in the cycle after the `fe` that samples the stop bit. The new data is visible in that same cycle.
- `parity_error` and `frame_error` pulse in the same cycle position as `input_arrived_flag` would. The timeout `frame_error` pulses in the cycle after the counter reaches `TIMEOUT_CYCLES`.
- Each pulse is exactly 1 cycle. At most one of the three pulses is asserted in any cycle.
- `busy` rises in the cycle after the start-bit `fe` and falls in the same cycle as the frame-end pulse.
- A PS/2 clock glitch shorter than `FILTER_LEN` cycles produces no `fe`.

## Test plan
- **Valid frame.** With the PS/2 clock period at 40 µs-equivalent (≥4×`FILTER_LEN` cycles per phase), send 0x1C as bits 0, 0,0,1,1,1,0,0,0, parity 0, stop 1. Required: `keyboard_input_data`=0x1C, exactly one `input_arrived_flag` pulse, no error pulse, `busy` low afterwards.
- **Parity error.** Send 0x1C with parity 1. Required: one `parity_error` pulse, no flag, `keyboard_input_data` keeps its previous value.
- **Break suppression.** Send 0x1C, then 0xF0, then 0x1C. Required: exactly one flag (for the first 0x1C). Repeat with `SUPPRESS_BREAK`=0: three flags, with data 0x1C, 0xF0, 0x1C.
- **Timeout.** Send a start bit and 5 data bits, then hold `ps2c` high. Required: after `TIMEOUT_CYCLES` cycles, one `frame_error` pulse and a return to IDLE. A following valid 0x5A frame is then delivered correctly.
- **Glitch and bad stop.** Inject a `FILTER_LEN`-1 cycle low glitch on `ps2c` in IDLE: no state change. Send 0x1C with stop bit 0: one `frame_error` pulse and no flag.
- **Reset mid-frame.** Assert `reset` for 1 cycle after the 4th data bit. Required: all outputs return to their reset values with no error pulse, and the next full 0x29 frame is delivered.

Source files
------------

// File: rtl/ps2_keyboard_receiver.sv
`default_nettype none
// ============================================================================
// Module   : ps2_keyboard_receiver
// Purpose  : PS/2 keyboard frame receiver delivering validated scan codes
//            and a one-cycle arrival pulse to the input register / FGI path.
// Revision : 1.0
// ============================================================================
module ps2_keyboard_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter bit SUPPRESS_BREAK = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c,
    input  logic       ps2d,
    input  logic       rx_en,
    output logic [7:0] keyboard_input_data,
    output logic       input_arrived_flag,
    output logic       parity_error,
    output logic       frame_error,
    output logic       busy
);

    localparam int                c_tcnt_w   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_tcnt_w-1:0] c_timeout = c_tcnt_w'(TIMEOUT_CYCLES);
    localparam logic [3:0]        c_filt_max = 4'(FILTER_LEN - 1);
    localparam logic [7:0]        c_break    = 8'hF0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    logic                r_ps2c_s1, r_ps2c_s2, r_ps2d_s1, r_ps2d_s2;
    logic [3:0]          r_fcnt;
    logic                r_fc, r_fc_d;
    logic                w_fe;

    state_t              r_state, w_state_nxt;
    logic [2:0]          r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0]          r_shift, w_shift_nxt;
    logic                r_parity, w_parity_nxt;
    logic [c_tcnt_w-1:0] r_tcnt, w_tcnt_nxt;
    logic                r_break_pending, w_break_pending_nxt;
    logic [7:0]          r_data, w_data_nxt;
    logic                r_flag, w_flag_nxt;
    logic                r_perr, w_perr_nxt;
    logic                r_ferr, w_ferr_nxt;

    // Synchronisers and the PS/2 clock deglitch filter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ps2c_s1 <= 1'b1;
            r_ps2c_s2 <= 1'b1;
            r_ps2d_s1 <= 1'b1;
            r_ps2d_s2 <= 1'b1;
            r_fcnt    <= 4'd0;
            r_fc      <= 1'b1;
            r_fc_d    <= 1'b1;
        end else begin
            r_ps2c_s1 <= ps2c;
            r_ps2c_s2 <= r_ps2c_s1;
            r_ps2d_s1 <= ps2d;
            r_ps2d_s2 <= r_ps2d_s1;
            r_fc_d    <= r_fc;
            if (r_ps2c_s2 == r_fc) begin
                r_fcnt <= 4'd0;
            end else if (r_fcnt == c_filt_max) begin
                r_fcnt <= 4'd0;
                r_fc   <= r_ps2c_s2;
            end else begin
                r_fcnt <= r_fcnt + 4'd1;
            end
        end
    end

    assign w_fe = r_fc_d & ~r_fc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_bit_cnt       <= 3'd0;
            r_shift         <= 8'h00;
            r_parity        <= 1'b0;
            r_tcnt          <= '0;
            r_break_pending <= 1'b0;
            r_data          <= 8'h00;
            r_flag          <= 1'b0;
            r_perr          <= 1'b0;
            r_ferr          <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_bit_cnt       <= w_bit_cnt_nxt;
            r_shift         <= w_shift_nxt;
            r_parity        <= w_parity_nxt;
            r_tcnt          <= w_tcnt_nxt;
            r_break_pending <= w_break_pending_nxt;
            r_data          <= w_data_nxt;
            r_flag          <= w_flag_nxt;
            r_perr          <= w_perr_nxt;
            r_ferr          <= w_ferr_nxt;
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        w_bit_cnt_nxt       = r_bit_cnt;
        w_shift_nxt         = r_shift;
        w_parity_nxt        = r_parity;
        w_break_pending_nxt = r_break_pending;
        w_data_nxt          = r_data;
        w_flag_nxt          = 1'b0;
        w_perr_nxt          = 1'b0;
        w_ferr_nxt          = 1'b0;

        if (r_state == S_IDLE) begin
            if (w_fe && !r_ps2d_s2 && rx_en) begin
                w_state_nxt   = S_DATA;
                w_bit_cnt_nxt = 3'd0;
            end
        end else if (w_fe) begin
            case (r_state)
                S_DATA: begin
                    w_shift_nxt   = {r_ps2d_s2, r_shift[7:1]};
                    w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = S_PARITY;
                    end
                end
                S_PARITY: begin
                    w_parity_nxt = r_ps2d_s2;
                    w_state_nxt  = S_STOP;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    // Stop-bit failure outranks a parity failure
                    if (!r_ps2d_s2) begin
                        w_ferr_nxt          = 1'b1;
                        w_break_pending_nxt = 1'b0;
                    end else if (!(^{r_shift, r_parity})) begin
                        w_perr_nxt          = 1'b1;
                        w_break_pending_nxt = 1'b0;
                    end else if (SUPPRESS_BREAK && (r_shift == c_break)) begin
                        w_break_pending_nxt = 1'b1;
                    end else if (SUPPRESS_BREAK && r_break_pending) begin
                        w_break_pending_nxt = 1'b0;
                    end else begin
                        w_data_nxt = r_shift;
                        w_flag_nxt = 1'b1;
                    end
                end
            endcase
        end else if (r_tcnt == c_timeout) begin
            w_state_nxt         = S_IDLE;
            w_ferr_nxt          = 1'b1;
            w_break_pending_nxt = 1'b0;
        end

        if ((w_state_nxt == S_IDLE) || w_fe) begin
            w_tcnt_nxt = '0;
        end else begin
            w_tcnt_nxt = r_tcnt + 1'b1;
        end
    end

    assign keyboard_input_data = r_data;
    assign input_arrived_flag  = r_flag;
    assign parity_error        = r_perr;
    assign frame_error         = r_ferr;
    assign busy                = (r_state != S_IDLE);

endmodule
`default_nettype wire
